// File: rtl/rv32_pkg.sv
// Shared RV32I writeback encodings: result-source selects, load funct3 codes
// and the writeback FSM state type.
package rv32_pkg;
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {IDLE, WAIT_RESP} wb_state_e;
endpackage

// File: rtl/wb_stage_load_align.sv
// Extracts the addressed byte/half/word from an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic [31:0] data
);
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        byte_v  = shifted[7:0];
        // Half lane picked by addr[1] only; misalignment is caught upstream.
        half_v  = addr[1] ? rdata[31:16] : rdata[15:0];
        data    = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_v[7]}}, byte_v};
            F3_LH:   data = {{16{half_v[15]}}, half_v};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, byte_v};
            F3_LHU:  data = {16'd0, half_v};
            default: data = '0;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: one retiring instruction per handshake, waits for the
// load response with a timeout, registers the regfile write pulse, counts instret.
module wb_stage
    import rv32_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    output logic             m_ready,
    input  logic [4:0]       m_rd,
    input  logic             m_reg_we,
    input  logic [1:0]       m_wb_sel,
    input  logic [2:0]       m_funct3,
    input  logic [31:0]      m_alu_result,
    input  logic [31:0]      m_pc4,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_wa,
    output logic [31:0]      rf_wdata,
    output logic             load_fault,
    output logic [CNT_W-1:0] instret
);
    localparam int TW = $clog2(LOAD_TIMEOUT) + 1;

    wb_state_e   state_q, state_d;
    logic [TW-1:0] tmo_q;
    logic [4:0]  ld_rd_q;
    logic        ld_we_q;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_addr_q;
    logic [31:0] ld_data;

    logic        accept, commit, fault_d, we_d, tmo_hit;
    logic [4:0]  wa_d;
    logic [31:0] wd_d;

    load_align u_align (
        .rdata  (dmem_rdata),
        .funct3 (ld_f3_q),
        .addr   (ld_addr_q),
        .data   (ld_data)
    );

    assign tmo_hit = (tmo_q == TW'(LOAD_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        m_ready = (state_q == IDLE);
        accept  = m_valid && m_ready;
        commit  = 1'b0;
        fault_d = 1'b0;
        we_d    = 1'b0;
        wa_d    = m_rd;
        wd_d    = m_alu_result;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (m_wb_sel == WB_SEL_LOAD) begin
                        state_d = WAIT_RESP;
                    end else begin
                        commit = 1'b1;
                        we_d   = m_reg_we && (m_rd != 5'd0);
                        wd_d   = (m_wb_sel == WB_SEL_PC4) ? m_pc4 : m_alu_result;
                    end
                end
            end
            WAIT_RESP: begin
                // A response on the last allowed cycle still completes the load.
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                    we_d    = ld_we_q && (ld_rd_q != 5'd0);
                    wa_d    = ld_rd_q;
                    wd_d    = ld_data;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wdata   <= '0;
            load_fault <= 1'b0;
            instret    <= '0;
            tmo_q      <= '0;
            ld_rd_q    <= '0;
            ld_we_q    <= 1'b0;
            ld_f3_q    <= '0;
            ld_addr_q  <= '0;
        end else begin
            rf_we      <= we_d;
            load_fault <= fault_d;
            if (we_d) begin
                rf_wa    <= wa_d;
                rf_wdata <= wd_d;
            end
            if (commit) instret <= instret + CNT_W'(1);
            if (state_q == IDLE && accept && m_wb_sel == WB_SEL_LOAD) begin
                ld_rd_q   <= m_rd;
                ld_we_q   <= m_reg_we;
                ld_f3_q   <= m_funct3;
                ld_addr_q <= m_alu_result[1:0];
                tmo_q     <= '0;
            end else if (state_q == WAIT_RESP && !dmem_rvalid) begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a behavioural model of
// the retirement rules (result select, load extraction, timeout, instret).
module tb_wb_stage;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid, m_ready, m_reg_we, dmem_rvalid;
    logic [4:0]  m_rd;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu_result, m_pc4, dmem_rdata;
    logic        rf_we, load_fault;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wdata;
    logic [63:0] instret;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] e_instret;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;

    wb_stage #(.LOAD_TIMEOUT(TMO), .CNT_W(64)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_reg_we(m_reg_we),
        .m_wb_sel(m_wb_sel), .m_funct3(m_funct3), .m_alu_result(m_alu_result),
        .m_pc4(m_pc4), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
        .load_fault(load_fault), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w / (32'd1 << (8 * a))) % 256;
        h = (w / (32'd1 << (16 * a[1]))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        m_valid = 0; m_rd = 0; m_reg_we = 0; m_wb_sel = 0; m_funct3 = 0;
        m_alu_result = 0; m_pc4 = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        e_instret = 0; e_wa = 0; e_wd = 0;
        repeat (2) @(negedge clk);
        nvec++;
        if (rf_we !== 0 || rf_wa !== 0 || rf_wdata !== 0 || load_fault !== 0 ||
            instret !== 0 || m_ready !== 1) begin
            nerr++;
            $display("FAIL reset: we=%b wa=%0d wd=%h flt=%b ir=%0d rdy=%b, want 0/0/0/0/0/1",
                     rf_we, rf_wa, rf_wdata, load_fault, instret, m_ready);
        end
        reset = 0;
        @(negedge clk);
    endtask

    // Non-load retirement; fixed directed vectors first, then random ones.
    task automatic test_alu();
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [31:0] alu, pc4, ewd;
        logic        ewe;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                rd = 5; we = 1; sel = 0; alu = 32'h1234_5678; pc4 = 32'h4;
            end else if (i == 1) begin
                rd = 0; we = 1; sel = 2; alu = 32'hDEAD_0000; pc4 = 32'h100;
            end else begin
                rd = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
                sel = 2'($urandom_range(0, 2)); if (sel == 1) sel = 3;
                alu = $urandom; pc4 = $urandom;
            end
            @(negedge clk);
            nvec++;
            if (m_ready !== 1) begin
                nerr++; $display("FAIL alu_ready[%0d]: got %b want 1", i, m_ready);
            end
            m_valid = 1; m_rd = rd; m_reg_we = we; m_wb_sel = sel;
            m_alu_result = alu; m_pc4 = pc4; m_funct3 = 3'($urandom);
            @(posedge clk); #1 m_valid = 0;
            ewd = (sel == 2) ? pc4 : alu;
            ewe = we && rd != 0;
            e_instret++;
            if (ewe) begin e_wa = rd; e_wd = ewd; end
            @(negedge clk);
            nvec++;
            if (rf_we !== ewe || rf_wa !== e_wa || rf_wdata !== e_wd || instret !== e_instret) begin
                nerr++;
                $display("FAIL alu[%0d]: we=%b wa=%0d wd=%h ir=%0d, want %b %0d %h %0d",
                         i, rf_we, rf_wa, rf_wdata, instret, ewe, e_wa, e_wd, e_instret);
            end
            @(negedge clk);
            nvec++;
            if (rf_we !== 0 || rf_wa !== e_wa || rf_wdata !== e_wd) begin
                nerr++;
                $display("FAIL alu_hold[%0d]: we=%b wa=%0d wd=%h, want 0 %0d %h",
                         i, rf_we, rf_wa, rf_wdata, e_wa, e_wd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        pend, pwe;
        logic [4:0]  prd;
        logic [31:0] pwd;
        pend = 0; pwe = 0; prd = 0; pwd = 0;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (pend) begin
                e_instret++;
                if (pwe) begin e_wa = prd; e_wd = pwd; end
                nvec++;
                if (rf_we !== pwe || rf_wa !== e_wa || rf_wdata !== e_wd ||
                    instret !== e_instret || m_ready !== 1) begin
                    nerr++;
                    $display("FAIL b2b[%0d]: we=%b wa=%0d wd=%h ir=%0d rdy=%b, want %b %0d %h %0d 1",
                             i, rf_we, rf_wa, rf_wdata, instret, m_ready, pwe, e_wa, e_wd, e_instret);
                end
            end
            if (i < 20) begin
                m_valid = 1; m_rd = 5'($urandom); m_reg_we = 1'($urandom);
                m_wb_sel = (($urandom % 2) == 0) ? 2'd0 : 2'd2;
                m_alu_result = $urandom; m_pc4 = $urandom;
                pend = 1; pwe = m_reg_we && m_rd != 0; prd = m_rd;
                pwd = (m_wb_sel == 2) ? m_pc4 : m_alu_result;
            end else begin
                m_valid = 0; pend = 0;
            end
        end
    endtask

    // One load with the response `dly` cycles after the first WAIT_RESP cycle.
    task automatic load_one(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w,
                            input int dly, input logic [4:0] rd, input logic we);
        logic        ewe;
        logic [31:0] v;
        @(negedge clk);
        m_valid = 1; m_rd = rd; m_reg_we = we; m_wb_sel = 1; m_funct3 = f3;
        m_alu_result = {$urandom_range(0, 1023), a}; m_pc4 = $urandom;
        dmem_rvalid = 1; dmem_rdata = ~w;  // response in the accept cycle must be ignored
        @(posedge clk); #1 m_valid = 0; dmem_rvalid = 0;
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            nvec++;
            if (m_ready !== 0 || rf_we !== 0) begin
                nerr++;
                $display("FAIL load_wait[%0d]: rdy=%b we=%b, want 0 0", k, m_ready, rf_we);
            end
        end
        @(negedge clk);
        dmem_rvalid = 1; dmem_rdata = w;
        @(posedge clk); #1 dmem_rvalid = 0; dmem_rdata = $urandom;
        v = ref_load(f3, a, w);
        ewe = we && rd != 0;
        e_instret++;
        if (ewe) begin e_wa = rd; e_wd = v; end
        @(negedge clk);
        nvec++;
        if (rf_we !== ewe || rf_wa !== e_wa || rf_wdata !== e_wd || instret !== e_instret ||
            m_ready !== 1 || load_fault !== 0) begin
            nerr++;
            $display("FAIL load f3=%0d a=%0d w=%h: we=%b wa=%0d wd=%h ir=%0d rdy=%b flt=%b, want %b %0d %h %0d 1 0",
                     f3, a, w, rf_we, rf_wa, rf_wdata, instret, m_ready, load_fault,
                     ewe, e_wa, e_wd, e_instret);
        end
    endtask

    task automatic test_loads();
        logic [2:0] f3;
        load_one(3'b000, 2'b11, 32'h80FF_0000, 2, 5'd7, 1'b1);
        load_one(3'b101, 2'b10, 32'hBEEF_1234, 0, 5'd8, 1'b1);
        load_one(3'b001, 2'b10, 32'hBEEF_1234, 1, 5'd9, 1'b1);
        load_one(3'b010, 2'b00, 32'hCAFE_F00D, TMO - 1, 5'd31, 1'b1);
        load_one(3'b110, 2'b01, 32'hFFFF_FFFF, 0, 5'd10, 1'b1);
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom);
            load_one(f3, 2'($urandom), $urandom, int'($urandom_range(0, TMO - 1)),
                     5'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_timeout();
        logic [63:0] ir0;
        ir0 = e_instret;
        @(negedge clk);
        m_valid = 1; m_rd = 5'd12; m_reg_we = 1; m_wb_sel = 1; m_funct3 = 3'b010;
        m_alu_result = 32'h1000;
        @(posedge clk); #1 m_valid = 0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            nvec++;
            if (m_ready !== 0 || load_fault !== 0 || rf_we !== 0) begin
                nerr++;
                $display("FAIL tmo_wait[%0d]: rdy=%b flt=%b we=%b, want 0 0 0", k, m_ready, load_fault, rf_we);
            end
        end
        @(negedge clk);
        nvec++;
        if (load_fault !== 1 || rf_we !== 0 || instret !== ir0 || m_ready !== 1) begin
            nerr++;
            $display("FAIL tmo_fault: flt=%b we=%b ir=%0d rdy=%b, want 1 0 %0d 1",
                     load_fault, rf_we, instret, m_ready, ir0);
        end
        @(negedge clk);
        nvec++;
        if (load_fault !== 0 || rf_wa !== e_wa || rf_wdata !== e_wd) begin
            nerr++;
            $display("FAIL tmo_pulse: flt=%b wa=%0d wd=%h, want 0 %0d %h", load_fault, rf_wa, rf_wdata, e_wa, e_wd);
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        m_valid = 1; m_rd = 5'd3; m_reg_we = 1; m_wb_sel = 1; m_funct3 = 3'b010;
        @(posedge clk); #1 m_valid = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        e_instret = 0; e_wa = 0; e_wd = 0;
        #1;
        nvec++;
        if (m_ready !== 1 || rf_we !== 0 || instret !== 0 || rf_wa !== 0 || rf_wdata !== 0) begin
            nerr++;
            $display("FAIL mid_reset: rdy=%b we=%b ir=%0d wa=%0d wd=%h, want 1 0 0 0 0",
                     m_ready, rf_we, instret, rf_wa, rf_wdata);
        end
        @(negedge clk); reset = 0;
        @(negedge clk); dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1 dmem_rvalid = 0;
        @(negedge clk);
        nvec++;
        if (rf_we !== 0 || load_fault !== 0 || instret !== 0 || m_ready !== 1) begin
            nerr++;
            $display("FAIL late_rvalid: we=%b flt=%b ir=%0d rdy=%b, want 0 0 0 1",
                     rf_we, load_fault, instret, m_ready);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_loads();
        test_timeout();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
